// File: rtl/up_cmd_bridge_if.sv
// Byte-stream and register-bus signals of the command bridge.
//
// Handshake rule for both byte streams (rx_*, tx_*): a byte moves on a
// clock edge only when valid and ready are both 1 in that cycle. The
// sender keeps data stable while valid is high and ready is low.
interface up_cmd_bridge_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        up_cs;
  logic        up_wr;
  logic        up_rd;
  logic [31:0] up_addr;
  logic [31:0] up_data_wr;
  logic [31:0] up_data_rd;
  logic        up_busy;

  // Bridge side: consumes commands, produces responses, masters the bus.
  modport master (
    input  rx_data, rx_valid, tx_ready, up_data_rd, up_busy,
    output rx_ready, tx_data, tx_valid, up_cs, up_wr, up_rd, up_addr, up_data_wr
  );

  // Environment side: command source, response sink and register bus.
  modport slave (
    output rx_data, rx_valid, tx_ready, up_data_rd, up_busy,
    input  rx_ready, tx_data, tx_valid, up_cs, up_wr, up_rd, up_addr, up_data_wr
  );
endinterface

// File: rtl/up_cmd_bridge.sv
// Byte-stream to register-bus command bridge.
// Frames: opcode ('W' 0x57 / 'R' 0x52), 4 address bytes MSB first, then
// 4 write-data bytes MSB first for writes. One bus strobe per frame, then
// a response: 'K' (write ok), 'D'+4 data bytes (read ok), 'T' (timeout),
// 'E' (unknown opcode).
module up_cmd_bridge #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic            clk,
  input  logic            rst,
  up_cmd_bridge_if.master bus,
  output logic [2:0]      state_dbg
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ADDR   = 3'd1;
  localparam logic [2:0] S_WDATA  = 3'd2;
  localparam logic [2:0] S_STROBE = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;
  localparam logic [2:0] S_RESP   = 3'd5;

  localparam logic [7:0] OP_WR    = 8'h57;
  localparam logic [7:0] OP_RD    = 8'h52;
  localparam logic [7:0] RSP_ERR  = 8'h45;
  localparam logic [7:0] RSP_TMO  = 8'h54;
  localparam logic [7:0] RSP_OK   = 8'h4B;
  localparam logic [7:0] RSP_DATA = 8'h44;

  // Last busy cycle index before the access is abandoned.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  logic [2:0]  state;
  logic        op_wr;
  logic [1:0]  byte_cnt;
  logic [15:0] tmo_cnt;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  // Response bytes, current byte in the top 8 bits, shifted up per transfer.
  logic [39:0] resp_sr;
  // Bytes still to send, including the one currently presented.
  logic [2:0]  resp_left;
  logic        in_rx_state;
  logic        rx_fire;
  logic        tx_fire;

  // rx_ready is gated by rst so it reads 0 for the whole reset pulse and
  // rises in the very first cycle after rst drops.
  assign in_rx_state    = (state == S_IDLE) || (state == S_ADDR) || (state == S_WDATA);
  assign bus.rx_ready   = in_rx_state && !rst;
  assign rx_fire        = bus.rx_valid && bus.rx_ready;
  assign bus.tx_valid   = (state == S_RESP);
  assign bus.tx_data    = resp_sr[39:32];
  assign tx_fire        = bus.tx_valid && bus.tx_ready;
  assign bus.up_cs      = (state == S_STROBE);
  assign bus.up_wr      = (state == S_STROBE) && op_wr;
  assign bus.up_rd      = (state == S_STROBE) && !op_wr;
  assign bus.up_addr    = addr_q;
  assign bus.up_data_wr = wdata_q;
  assign state_dbg      = state;

  // Frame decode, bus access sequencing and response serialisation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      op_wr     <= 1'b0;
      byte_cnt  <= 2'd0;
      tmo_cnt   <= 16'd0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      resp_sr   <= 40'd0;
      resp_left <= 3'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (rx_fire) begin
            if (bus.rx_data == OP_WR || bus.rx_data == OP_RD) begin
              op_wr    <= (bus.rx_data == OP_WR);
              byte_cnt <= 2'd0;
              state    <= S_ADDR;
            end else begin
              resp_sr   <= {RSP_ERR, 32'd0};
              resp_left <= 3'd1;
              state     <= S_RESP;
            end
          end
        end
        S_ADDR: begin
          if (rx_fire) begin
            addr_q   <= {addr_q[23:0], bus.rx_data};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              state <= op_wr ? S_WDATA : S_STROBE;
            end
          end
        end
        S_WDATA: begin
          if (rx_fire) begin
            wdata_q  <= {wdata_q[23:0], bus.rx_data};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              state <= S_STROBE;
            end
          end
        end
        S_STROBE: begin
          tmo_cnt <= 16'd0;
          state   <= S_WAIT;
        end
        S_WAIT: begin
          if (!bus.up_busy) begin
            if (op_wr) begin
              resp_sr   <= {RSP_OK, 32'd0};
              resp_left <= 3'd1;
            end else begin
              resp_sr   <= {RSP_DATA, bus.up_data_rd};
              resp_left <= 3'd5;
            end
            state <= S_RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
            if (tmo_cnt == TMO_LAST) begin
              resp_sr   <= {RSP_TMO, 32'd0};
              resp_left <= 3'd1;
              state     <= S_RESP;
            end
          end
        end
        S_RESP: begin
          if (tx_fire) begin
            resp_sr   <= {resp_sr[31:0], 8'd0};
            resp_left <= resp_left - 3'd1;
            if (resp_left == 3'd1) begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_up_cmd_bridge.sv
// Self-checking bench for up_cmd_bridge: directed vector table, random
// frames against a frame-level reference model, and reset corner cases.
module tb_up_cmd_bridge;
  localparam int TB_TIMEOUT = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] state_dbg;

  up_cmd_bridge_if bus();

  up_cmd_bridge #(.TIMEOUT(TB_TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    int          resp_off;
  } strobe_t;

  typedef struct {
    logic [7:0]  b [9];
    int          n;
    int          busy;
    logic [31:0] rdata;
    bit          bp;
  } vec_t;

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [7:0]  exp_q[$];
  strobe_t     exp_s_q[$];
  logic [7:0]  rx_q[$];
  logic [7:0]  frm[$];
  int          cfg_busy = 0;
  logic [31:0] cfg_rdata = 32'd0;
  bit          bp_mode = 1'b0;
  int          busy_left = 0;
  bit          holding = 1'b0;
  logic [7:0]  held_data = 8'd0;
  int          stall_left = 0;
  int          last_rx_cyc = -100;
  int          exp_resp_cyc = -1;
  int          strobe_cnt = 0;
  bit          in_access = 1'b0;
  logic [31:0] acc_addr = 32'd0;
  logic [31:0] acc_data = 32'd0;
  bit          prev_tx_valid = 1'b0;
  vec_t        vt[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: expected strobe and response bytes of the frame in frm.
  task automatic expect_frame(input int busy, input logic [31:0] rdata);
    strobe_t s;
    int      waitc;
    bit      tmo;
    if (frm[0] == 8'h57 || frm[0] == 8'h52) begin
      s.wr   = (frm[0] == 8'h57);
      s.addr = {frm[1], frm[2], frm[3], frm[4]};
      s.data = s.wr ? {frm[5], frm[6], frm[7], frm[8]} : 32'd0;
      tmo    = (busy >= TB_TIMEOUT);
      waitc  = tmo ? TB_TIMEOUT : busy + 1;
      s.resp_off = 1 + waitc;
      exp_s_q.push_back(s);
      if (tmo) exp_q.push_back(8'h54);
      else if (s.wr) exp_q.push_back(8'h4B);
      else begin
        exp_q.push_back(8'h44);
        for (int i = 3; i >= 0; i--) exp_q.push_back(rdata[8*i +: 8]);
      end
    end else begin
      exp_q.push_back(8'h45);
    end
    cfg_busy  = busy;
    cfg_rdata = rdata;
  endtask

  // One cycle: monitor outputs, drive bus responder, tx sink and rx source.
  task automatic step();
    strobe_t s;
    @(negedge clk);
    cyc++;
    if (in_access) begin
      if (bus.rx_ready) in_access = 1'b0;
      else begin
        check("addr_hold", bus.up_addr, acc_addr);
        check("wdata_hold", bus.up_data_wr, acc_data);
      end
    end
    if (bus.up_cs) begin
      strobe_cnt++;
      if (exp_s_q.size() == 0) check("unexpected_strobe", 1, 0);
      else begin
        s = exp_s_q.pop_front();
        check("strobe_kind", {bus.up_wr, bus.up_rd}, s.wr ? 2'b10 : 2'b01);
        check("strobe_addr", bus.up_addr, s.addr);
        if (s.wr) check("strobe_wdata", bus.up_data_wr, s.data);
        check("strobe_latency", cyc - last_rx_cyc, 1);
        exp_resp_cyc = cyc + s.resp_off;
      end
      in_access = 1'b1;
      acc_addr  = bus.up_addr;
      acc_data  = bus.up_data_wr;
      busy_left = cfg_busy;
      bus.up_busy    = 1'b1;
      bus.up_data_rd = $urandom;
    end else if (busy_left > 0) begin
      busy_left--;
      bus.up_busy    = 1'b1;
      bus.up_data_rd = $urandom;
    end else begin
      bus.up_busy    = 1'b0;
      bus.up_data_rd = cfg_rdata;
    end
    if (bus.tx_valid) begin
      if (!prev_tx_valid && exp_resp_cyc >= 0) begin
        check("resp_latency", cyc, exp_resp_cyc);
        exp_resp_cyc = -1;
      end
      check("rx_ready_in_resp", bus.rx_ready, 0);
      if (holding) check("tx_hold", bus.tx_data, held_data);
      else begin
        holding    = 1'b1;
        held_data  = bus.tx_data;
        stall_left = bp_mode ? 10 : $urandom_range(0, 2);
      end
      if (stall_left > 0) begin
        stall_left--;
        bus.tx_ready = 1'b0;
      end else begin
        bus.tx_ready = 1'b1;
        holding = 1'b0;
        if (exp_q.size() == 0) check("tx_extra_byte", bus.tx_data, 0);
        else check("tx_byte", bus.tx_data, exp_q.pop_front());
      end
    end else begin
      holding = 1'b0;
      bus.tx_ready = 1'($urandom_range(0, 1));
    end
    prev_tx_valid = bus.tx_valid;
    if (rx_q.size() > 0 && $urandom_range(0, 3) != 0) begin
      bus.rx_valid = 1'b1;
      bus.rx_data  = rx_q[0];
      if (bus.rx_ready) begin
        void'(rx_q.pop_front());
        last_rx_cyc = cyc;
      end
    end else begin
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'($urandom);
    end
  endtask

  // Send frm, then run until the response is drained and the bridge is idle.
  task automatic run_frame(input int busy, input logic [31:0] rdata, input bit bp);
    bit done = 1'b0;
    expect_frame(busy, rdata);
    bp_mode = bp;
    foreach (frm[i]) rx_q.push_back(frm[i]);
    for (int k = 0; k < 1000 && !done; k++) begin
      step();
      done = (rx_q.size() == 0) && (exp_q.size() == 0) && bus.rx_ready && !bus.tx_valid;
    end
    check("frame_done", done, 1);
    check("frame_strobes_left", exp_s_q.size(), 0);
    check("frame_tx_left", exp_q.size(), 0);
    exp_q.delete();
    exp_s_q.delete();
    rx_q.delete();
    bp_mode = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    cyc++;
    rst = 1'b1;
    bus.rx_valid = 1'b0;
    @(negedge clk);
    cyc++;
    check("rst_rx_ready", bus.rx_ready, 0);
    check("rst_tx_valid", bus.tx_valid, 0);
    check("rst_tx_data", bus.tx_data, 0);
    check("rst_strobes", {bus.up_cs, bus.up_wr, bus.up_rd}, 0);
    check("rst_up_addr", bus.up_addr, 0);
    check("rst_up_data_wr", bus.up_data_wr, 0);
    rst = 1'b0;
    #1;
    check("rst_release_rx_ready", bus.rx_ready, 1);
    exp_q.delete();
    exp_s_q.delete();
    rx_q.delete();
    exp_resp_cyc = -1;
    in_access = 1'b0;
    holding = 1'b0;
    prev_tx_valid = 1'b0;
  endtask

  task automatic set_write_frame(input logic [31:0] a, input logic [31:0] d);
    frm = '{8'h57, a[31:24], a[23:16], a[15:8], a[7:0], d[31:24], d[23:16], d[15:8], d[7:0]};
  endtask

  initial begin
    int s0;
    int r;
    logic [7:0] op;
    rst = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data = 8'd0;
    bus.tx_ready = 1'b0;
    bus.up_busy = 1'b0;
    bus.up_data_rd = 32'd0;

    // Power-on reset
    repeat (3) @(negedge clk);
    check("por_rx_ready", bus.rx_ready, 0);
    check("por_tx_valid", bus.tx_valid, 0);
    check("por_tx_data", bus.tx_data, 0);
    check("por_strobes", {bus.up_cs, bus.up_wr, bus.up_rd}, 0);
    check("por_up_addr", bus.up_addr, 0);
    check("por_up_data_wr", bus.up_data_wr, 0);
    rst = 1'b0;
    #1;
    check("por_release_rx_ready", bus.rx_ready, 1);

    // Directed vector table
    vt[0] = '{b: '{8'h57, 8'h00, 8'h00, 8'h00, 8'h10, 8'hDE, 8'hAD, 8'hBE, 8'hEF}, n: 9, busy: 0, rdata: 32'h0, bp: 1'b0};
    vt[1] = '{b: '{8'h52, 8'h00, 8'h00, 8'h01, 8'h00, 8'h0, 8'h0, 8'h0, 8'h0}, n: 5, busy: 5, rdata: 32'h12345678, bp: 1'b0};
    vt[2] = '{b: '{8'h52, 8'hCA, 8'hFE, 8'h00, 8'h04, 8'h0, 8'h0, 8'h0, 8'h0}, n: 5, busy: 40, rdata: 32'h99887766, bp: 1'b0};
    vt[3] = '{b: '{8'h00, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0}, n: 1, busy: 0, rdata: 32'h0, bp: 1'b0};
    vt[4] = '{b: '{8'h52, 8'h80, 8'h00, 8'h00, 8'h20, 8'h0, 8'h0, 8'h0, 8'h0}, n: 5, busy: 2, rdata: 32'hA5C30F96, bp: 1'b1};
    vt[5] = '{b: '{8'h57, 8'h01, 8'h02, 8'h03, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44}, n: 9, busy: 7, rdata: 32'h0, bp: 1'b0};
    vt[6] = '{b: '{8'h57, 8'h05, 8'h06, 8'h07, 8'h08, 8'h55, 8'h66, 8'h77, 8'h88}, n: 9, busy: 8, rdata: 32'h0, bp: 1'b0};
    for (int v = 0; v < 7; v++) begin
      frm.delete();
      for (int i = 0; i < vt[v].n; i++) frm.push_back(vt[v].b[i]);
      run_frame(vt[v].busy, vt[v].rdata, vt[v].bp);
    end

    // Random frames
    for (int t = 0; t < 30; t++) begin
      r = $urandom_range(0, 9);
      if (r < 2) begin
        do op = 8'($urandom); while (op == 8'h57 || op == 8'h52);
        frm = '{op};
      end else if (r < 6) begin
        set_write_frame($urandom, $urandom);
      end else begin
        frm = '{8'h52, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
      end
      run_frame($urandom_range(0, 10), $urandom, $urandom_range(0, 5) == 0);
    end

    // Reset after opcode + 3 address bytes, then a full write
    s0 = strobe_cnt;
    rx_q = '{8'h57, 8'h00, 8'h00, 8'h00};
    for (int k = 0; k < 100 && rx_q.size() > 0; k++) step();
    pulse_reset();
    set_write_frame(32'h0000_0044, 32'hCAFE_F00D);
    run_frame(1, 32'h0, 1'b0);
    check("mid_frame_strobe_count", strobe_cnt - s0, 1);

    // Reset during WAIT, then a full write
    frm = '{8'h52, 8'h00, 8'h00, 8'h02, 8'h00};
    expect_frame(40, 32'h1357_9BDF);
    rx_q = frm;
    s0 = strobe_cnt;
    for (int k = 0; k < 100 && strobe_cnt == s0; k++) step();
    check("wait_strobe_seen", strobe_cnt - s0, 1);
    repeat (3) step();
    pulse_reset();
    s0 = strobe_cnt;
    set_write_frame(32'h0000_0300, 32'h0BAD_CAFE);
    run_frame(0, 32'h0, 1'b0);
    check("mid_wait_strobe_count", strobe_cnt - s0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/up_cmd_bridge.md
UP_CMD_BRIDGE -- requirements
Module: up_cmd_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1023, meaning the number of busy-wait cycles before an access is aborted (range 1..65535).
REQ-002 SHALL have port clk, input, 1, the single clock for all logic; the downstream register-bus consumer's up_clk is driven from this clock.
REQ-003 SHALL have port rst, input, 1, a synchronous active-high reset.
REQ-004 SHALL have ports rx_data (input, 8), rx_valid (input, 1) and rx_ready (output, 1), the inbound command byte stream.
REQ-005 SHALL have ports tx_data (output, 8), tx_valid (output, 1) and tx_ready (input, 1), the outbound response byte stream.
REQ-006 SHALL have ports up_cs, up_wr and up_rd, each output, 1, the register-bus strobes.
REQ-007 SHALL have ports up_addr (output, 32) and up_data_wr (output, 32), the register-bus address and write data.
REQ-008 SHALL have ports up_data_rd (input, 32) and up_busy (input, 1), the register-bus read data and busy indication.

Function
REQ-009 SHALL transfer a byte on any stream only on a cycle where valid and ready are both 1.
REQ-010 SHALL decode command frames as: opcode byte, then 4 address bytes MSB first, then (for writes only) 4 data bytes MSB first.
- 0x57 ('W') = write.
- 0x52 ('R') = read.
REQ-011 SHALL implement states IDLE, ADDR, WDATA, STROBE, WAIT, RESP.
REQ-012 SHALL assert rx_ready = 1 only in IDLE, ADDR and WDATA.
REQ-013 SHALL, in IDLE, act on the accepted byte as follows:
- 0x57 or 0x52: latch the opcode and go to ADDR.
- Any other byte: go to RESP with the single byte 0x45 ('E').
REQ-014 SHALL, in ADDR, shift the 4 accepted bytes into up_addr using a 2-bit byte counter; after the 4th byte go to WDATA (write) or STROBE (read).
REQ-015 SHALL, in WDATA, shift the 4 accepted bytes into up_data_wr, then go to STROBE.
REQ-016 SHALL hold up_addr and up_data_wr stable from STROBE until the return to IDLE.
REQ-017 SHALL, in STROBE, assert up_cs = 1 and exactly one of up_wr/up_rd = 1 for exactly one cycle, then go to WAIT with the timeout counter cleared.
REQ-018 SHALL, in WAIT, sample up_busy every cycle starting the cycle after STROBE.
REQ-019 SHALL, on the first WAIT cycle with up_busy = 0, capture up_data_rd (reads only) and go to RESP.
REQ-020 SHALL, while up_busy = 1, increment the timeout counter each cycle.
REQ-021 SHALL, when the timeout counter reaches TIMEOUT, go to RESP with the single byte 0x54 ('T') and discard any later up_busy or up_data_rd.
REQ-022 SHALL produce these responses for a successful access:
- Write: the single byte 0x4B ('K').
- Read: 0x44 ('D') followed by the captured data, 4 bytes MSB first.
REQ-023 SHALL, in RESP, present each byte with tx_valid = 1 and hold tx_data stable until tx_ready = 1.
REQ-024 SHALL advance to the next byte on the cycle after a transfer, and return to IDLE on the cycle after the last byte's transfer.
REQ-025 SHALL accept no new command until the response is fully sent; back-pressure on tx stalls indefinitely with no timeout.
REQ-026 SHALL use a latency from the last command byte accepted to the STROBE cycle of exactly 1 cycle.
REQ-027 SHALL, when up_busy is 0 on the first WAIT cycle, present the first response byte 1 cycle later.
REQ-028 SHALL never issue more than one bus strobe per command frame.
REQ-029 SHALL treat a byte received in IDLE only as an opcode; there is no framing resync beyond the 'E' response.

Reset
REQ-030 SHALL, while rst = 1 at a clk edge, force:
- state IDLE;
- rx_ready = 0, tx_valid = 0, tx_data = 0x00;
- up_cs = up_wr = up_rd = 0;
- up_addr = 0, up_data_wr = 0;
- byte and timeout counters = 0.
REQ-031 SHALL assert rx_ready = 1 on the first cycle after rst deasserts.
REQ-032 SHALL, when reset hits mid-frame or mid-WAIT, discard the partial frame, emit no strobe or response, and leave captured data unused.

Verification
REQ-033 SHALL cover a write:
- Stimulus: bytes 57 00 00 00 10 DE AD BE EF, up_busy = 0.
- Response: one-cycle up_cs&up_wr with up_addr = 0x00000010 and up_data_wr = 0xDEADBEEF, then tx 0x4B.
REQ-034 SHALL cover a read:
- Stimulus: bytes 52 00 00 01 00, up_busy = 1 for 5 cycles, then 0 with up_data_rd = 0x12345678.
- Response: tx 44 12 34 56 78.
REQ-035 SHALL cover a timeout:
- Stimulus: TIMEOUT = 8, read with up_busy held at 1.
- Response: tx 0x54 after 8 WAIT cycles, and no capture.
REQ-036 SHALL cover a bad opcode:
- Stimulus: byte 0x00.
- Response: tx 0x45, with no strobe.
REQ-037 SHALL cover back-pressure:
- Stimulus: read with tx_ready = 0 for 10 cycles per byte.
- Response: each byte held stable, rx_ready = 0 throughout, and 5 bytes exact.
REQ-038 SHALL cover reset mid-frame:
- Stimulus: rst after 3 address bytes, then a full write.
- Response: only the second frame strobes, and a single 0x4B is sent.
